// File: rtl/des_key_scheduler.sv
// DES/3DES round-key generator: loads a 64-bit key, applies PC-1, then emits Rounds subkeys
// (PC-2 of the C/D register) one per valid/ready handshake, in encrypt or decrypt order.
module des_key_scheduler #(
  parameter int unsigned Rounds      = 16,
  parameter logic [15:0] ShiftMap    = 16'h8103,
  parameter bit          CheckParity = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        decrypt_i,
  input  logic [63:0] key_i,
  input  logic        sub_ready_i,
  output logic        sub_valid_o,
  output logic [47:0] sub_key_o,
  output logic [3:0]  round_idx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        par_err_o
);

  // Tables use DES 1-based bit numbering, bit 1 = MSB of the source vector.
  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [3:0] LastIdx = 4'(Rounds - 1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    int unsigned src;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      src = 64 - Pc1Tab[i];
      r[55-i] = k[src[5:0]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    int unsigned src;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      src = 56 - Pc2Tab[i];
      r[47-i] = cd[src[5:0]];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic even_parity_any(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (~^k[8*b +: 8]) bad = 1'b1;
    end
    return bad;
  endfunction

  state_e      state_q;
  logic [55:0] cd_q;
  logic [3:0]  round_idx_q;
  logic        dec_q;
  logic        sub_valid_q;
  logic        busy_q;
  logic        done_q;
  logic        par_err_q;

  logic [55:0] key_pc1;
  logic [55:0] cd_load;
  logic [55:0] cd_step;
  logic [3:0]  enc_sel;
  logic [3:0]  dec_sel;

  always_comb begin
    key_pc1 = pc1(key_i);
    // Encrypt preloads the round-1 rotation; decrypt starts from CD16, which equals CD0.
    if (decrypt_i) begin
      cd_load = key_pc1;
    end else begin
      cd_load = {rotl28(key_pc1[55:28], !ShiftMap[0]), rotl28(key_pc1[27:0], !ShiftMap[0])};
    end
    enc_sel = round_idx_q + 4'd1;
    dec_sel = 4'd15 - round_idx_q;
    if (dec_q) begin
      cd_step = {rotr28(cd_q[55:28], !ShiftMap[dec_sel]),
                 rotr28(cd_q[27:0],  !ShiftMap[dec_sel])};
    end else begin
      cd_step = {rotl28(cd_q[55:28], !ShiftMap[enc_sel]),
                 rotl28(cd_q[27:0],  !ShiftMap[enc_sel])};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cd_q        <= '0;
      round_idx_q <= '0;
      dec_q       <= 1'b0;
      sub_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            cd_q        <= cd_load;
            round_idx_q <= '0;
            dec_q       <= decrypt_i;
            busy_q      <= 1'b1;
            sub_valid_q <= 1'b1;
            par_err_q   <= CheckParity ? even_parity_any(key_i) : 1'b0;
            state_q     <= StEmit;
          end
        end
        StEmit: begin
          if (sub_ready_i) begin
            if (round_idx_q == LastIdx) begin
              sub_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StIdle;
            end else begin
              round_idx_q <= round_idx_q + 4'd1;
              cd_q        <= cd_step;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sub_valid_o = sub_valid_q;
  assign sub_key_o   = pc2(cd_q);
  assign round_idx_o = round_idx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign par_err_o   = par_err_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Bench for des_key_scheduler: table of key runs checked through an expected-subkey queue,
// plus hand-written reset-abort and 4-round sequences.
module tb_des_key_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start4, decrypt, sub_ready;
  logic [63:0] key;
  logic        sub_valid, busy, done, par_err;
  logic [47:0] sub_key;
  logic [3:0]  round_idx;
  logic        sub_valid4, busy4, done4, par_err4;
  logic [47:0] sub_key4;
  logic [3:0]  round_idx4;

  des_key_scheduler u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .decrypt_i(decrypt), .key_i(key),
    .sub_ready_i(sub_ready), .sub_valid_o(sub_valid), .sub_key_o(sub_key),
    .round_idx_o(round_idx), .busy_o(busy), .done_o(done), .par_err_o(par_err)
  );

  des_key_scheduler #(.Rounds(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .decrypt_i(decrypt), .key_i(key),
    .sub_ready_i(sub_ready), .sub_valid_o(sub_valid4), .sub_key_o(sub_key4),
    .round_idx_o(round_idx4), .busy_o(busy4), .done_o(done4), .par_err_o(par_err4)
  );

  typedef struct {
    logic [63:0] key;
    bit          dec;
    bit          rnd;
    bit          zero;
    bit          par;
    bit          poke;
  } vec_t;

  typedef struct {
    logic [3:0]  idx;
    logic [47:0] sk;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [47:0] enc_tab [16];
  vec_t        vecs [6];
  exp_t        exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   acc = 0;
    int   cyc = 0;
    int   gaps = 0;
    int   early = 0;
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.idx = 4'(k);
      e.sk  = v.zero ? 48'h0 : (v.dec ? enc_tab[15-k] : enc_tab[k]);
      exp_q.push_back(e);
    end
    key = v.key; decrypt = v.dec; sub_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    // Inputs after load must not matter.
    start = 1'b0; key = 64'hFFFF_0000_AAAA_5555; decrypt = ~v.dec;
    chk({tag, " valid_after_start"}, 64'(sub_valid), 64'd1);
    chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
    chk({tag, " par_err"}, 64'(par_err), 64'(v.par));
    while (acc < 16 && cyc < 400) begin
      sub_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = v.poke && (acc == 3 || acc == 15);
      @(negedge clk);
      cyc++;
      if (done) early++;
      if (!sub_valid) begin
        gaps++;
      end else if (exp_q.size() == 0) begin
        chk({tag, " unexpected_output"}, 64'(sub_valid), 64'd0);
      end else begin
        chk({tag, " sub_key"}, 64'(sub_key), 64'(exp_q[0].sk));
        chk({tag, " round_idx"}, 64'(round_idx), 64'(exp_q[0].idx));
        if (sub_ready) begin
          void'(exp_q.pop_front());
          acc++;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; sub_ready = 1'b0;
    chk({tag, " accepts"}, 64'(acc), 64'd16);
    chk({tag, " valid_gaps"}, 64'(gaps), 64'd0);
    chk({tag, " early_done"}, 64'(early), 64'd0);
    chk({tag, " done_pulse"}, 64'(done), 64'd1);
    chk({tag, " valid_end"}, 64'(sub_valid), 64'd0);
    chk({tag, " busy_end"}, 64'(busy), 64'd0);
    chk({tag, " par_err_held"}, 64'(par_err), 64'(v.par));
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, " idle_after"}, 64'(sub_valid), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; decrypt = 1'b0; sub_ready = 1'b0; key = '0;
    enc_tab = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{64'h133457799BBCDFF1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'h0000000000000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{64'h0101010101010101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{64'h133457799BBCDFF1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset sub_valid", 64'(sub_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset par_err", 64'(par_err), 64'd0);
    chk("reset round_idx", 64'(round_idx), 64'd0);
    chk("reset sub_key", 64'(sub_key), 64'd0);
    rst_n = 1'b1;
    sub_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_while_idle", 64'(sub_valid), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a run: abort with no done pulse.
    key = 64'h133457799BBCDFF1; decrypt = 1'b0; sub_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (sub_valid && round_idx == 4'd7) found = 1'b1;
      else @(posedge clk);
    end
    chk("rst_run reached_idx7", 64'(found), 64'd1);
    chk("rst_run key_idx7", 64'(sub_key), 64'(enc_tab[7]));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_run sub_valid", 64'(sub_valid), 64'd0);
    chk("rst_run busy", 64'(busy), 64'd0);
    chk("rst_run done", 64'(done), 64'd0);
    chk("rst_run round_idx", 64'(round_idx), 64'd0);
    chk("rst_run sub_key", 64'(sub_key), 64'd0);
    @(posedge clk); #1;
    chk("rst_run no_done_later", 64'(done), 64'd0);
    chk("rst_run stays_idle", 64'(sub_valid), 64'd0);

    // Four-round build.
    sub_ready = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("r4 valid%0d", k), 64'(sub_valid4), 64'd1);
      chk($sformatf("r4 key%0d", k), 64'(sub_key4), 64'(enc_tab[k]));
      chk($sformatf("r4 idx%0d", k), 64'(round_idx4), 64'(k));
      @(posedge clk); #1;
    end
    chk("r4 done", 64'(done4), 64'd1);
    chk("r4 valid_end", 64'(sub_valid4), 64'd0);
    chk("r4 busy_end", 64'(busy4), 64'd0);
    chk("r4 par_err", 64'(par_err4), 64'd0);
    sub_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
